// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin, held-grant sharing of one SPI master between two sequencers
module spi_master_arbiter #(
    parameter int DataWidth  = 8,
    parameter int GuardWidth = 16
) (
    input  logic                  Clk_i,
    input  logic                  Reset_n_i,
    input  logic [GuardWidth-1:0] ParamGuardPreset_i,
    input  logic                  Req0_Request_i,
    output logic                  Req0_Grant_o,
    input  logic                  Req0_Write_i,
    input  logic                  Req0_ReadNext_i,
    input  logic [DataWidth-1:0]  Req0_Data_i,
    input  logic                  Req0_CPOL_i,
    input  logic                  Req0_CPHA_i,
    input  logic                  Req0_LSBFE_i,
    output logic [DataWidth-1:0]  Req0_Data_o,
    output logic                  Req0_FIFOFull_o,
    output logic                  Req0_FIFOEmpty_o,
    output logic                  Req0_Transmission_o,
    input  logic                  Req1_Request_i,
    output logic                  Req1_Grant_o,
    input  logic                  Req1_Write_i,
    input  logic                  Req1_ReadNext_i,
    input  logic [DataWidth-1:0]  Req1_Data_i,
    input  logic                  Req1_CPOL_i,
    input  logic                  Req1_CPHA_i,
    input  logic                  Req1_LSBFE_i,
    output logic [DataWidth-1:0]  Req1_Data_o,
    output logic                  Req1_FIFOFull_o,
    output logic                  Req1_FIFOEmpty_o,
    output logic                  Req1_Transmission_o,
    output logic                  SPI_Write_o,
    output logic                  SPI_ReadNext_o,
    output logic [DataWidth-1:0]  SPI_Data_o,
    input  logic [DataWidth-1:0]  SPI_Data_i,
    input  logic                  SPI_FIFOFull_i,
    input  logic                  SPI_FIFOEmpty_i,
    input  logic                  SPI_Transmission_i,
    output logic                  SPI_CPOL_o,
    output logic                  SPI_CPHA_o,
    output logic                  SPI_LSBFE_o,
    output logic                  Busy_o
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] GRANT0  = 3'd1;
    localparam logic [2:0] GRANT1  = 3'd2;
    localparam logic [2:0] RELEASE = 3'd3;
    localparam logic [2:0] GUARD   = 3'd4;

    logic [2:0]            state;
    logic [2:0]            next_state;
    logic                  last;
    logic [GuardWidth-1:0] counter;
    logic                  drained;
    logic                  own0;
    logic                  own1;

    assign drained = !SPI_Transmission_i && SPI_FIFOEmpty_i;
    assign own0    = state == GRANT0;
    assign own1    = state == GRANT1;

    // next state: tie in Idle goes to whoever did not own the master last
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (Req0_Request_i && (!Req1_Request_i || last)) ? GRANT0 :
                                  Req1_Request_i ? GRANT1 : IDLE;
            GRANT0:  next_state = Req0_Request_i ? GRANT0 : RELEASE;
            GRANT1:  next_state = Req1_Request_i ? GRANT1 : RELEASE;
            RELEASE: next_state = !drained ? RELEASE :
                                  (ParamGuardPreset_i == '0) ? IDLE : GUARD;
            GUARD:   next_state = (counter <= GuardWidth'(1)) ? IDLE : GUARD;
            default: next_state = IDLE;
        endcase
    end

    // state, last owner, guard counter and SPI mode captured on grant entry
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state       <= IDLE;
            last        <= 1'b1;
            counter     <= '0;
            SPI_CPOL_o  <= 1'b0;
            SPI_CPHA_o  <= 1'b0;
            SPI_LSBFE_o <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == GRANT0) begin
                last        <= 1'b0;
                SPI_CPOL_o  <= Req0_CPOL_i;
                SPI_CPHA_o  <= Req0_CPHA_i;
                SPI_LSBFE_o <= Req0_LSBFE_i;
            end else if (state == IDLE && next_state == GRANT1) begin
                last        <= 1'b1;
                SPI_CPOL_o  <= Req1_CPOL_i;
                SPI_CPHA_o  <= Req1_CPHA_i;
                SPI_LSBFE_o <= Req1_LSBFE_i;
            end
            if (state == RELEASE && next_state == GUARD)
                counter <= ParamGuardPreset_i;
            else if (state == GUARD)
                counter <= counter - GuardWidth'(1);
        end
    end

    assign Req0_Grant_o        = own0;
    assign Req1_Grant_o        = own1;
    assign Busy_o              = state != IDLE;
    assign SPI_Write_o         = own0 ? Req0_Write_i : own1 ? Req1_Write_i : 1'b0;
    assign SPI_ReadNext_o      = own0 ? Req0_ReadNext_i : own1 ? Req1_ReadNext_i : 1'b0;
    assign SPI_Data_o          = own0 ? Req0_Data_i : own1 ? Req1_Data_i : '0;
    assign Req0_Data_o         = SPI_Data_i;
    assign Req1_Data_o         = SPI_Data_i;
    // a non-owner sees a full, busy master so it never tries to push a byte
    assign Req0_FIFOFull_o     = own0 ? SPI_FIFOFull_i : 1'b1;
    assign Req0_FIFOEmpty_o    = own0 ? SPI_FIFOEmpty_i : 1'b0;
    assign Req0_Transmission_o = own0 ? SPI_Transmission_i : 1'b1;
    assign Req1_FIFOFull_o     = own1 ? SPI_FIFOFull_i : 1'b1;
    assign Req1_FIFOEmpty_o    = own1 ? SPI_FIFOEmpty_i : 1'b0;
    assign Req1_Transmission_o = own1 ? SPI_Transmission_i : 1'b1;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter: scoreboard bench for the two-requester SPI master arbiter
module tb_spi_master_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] preset;
    logic        r0_req, r0_wr, r0_rn, r0_cpol, r0_cpha, r0_lsbfe;
    logic        r1_req, r1_wr, r1_rn, r1_cpol, r1_cpha, r1_lsbfe;
    logic [7:0]  r0_din, r1_din, r0_dout, r1_dout;
    logic        r0_grant, r0_full, r0_empty, r0_trans;
    logic        r1_grant, r1_full, r1_empty, r1_trans;
    logic        spi_wr, spi_rn, spi_cpol, spi_cpha, spi_lsbfe, busy;
    logic [7:0]  spi_dout, spi_din;
    logic        spi_full, spi_empty, spi_trans;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          exp_owner;
    int          owner;

    spi_master_arbiter dut (
        .Clk_i(clk), .Reset_n_i(rst_n), .ParamGuardPreset_i(preset),
        .Req0_Request_i(r0_req), .Req0_Grant_o(r0_grant), .Req0_Write_i(r0_wr),
        .Req0_ReadNext_i(r0_rn), .Req0_Data_i(r0_din), .Req0_CPOL_i(r0_cpol),
        .Req0_CPHA_i(r0_cpha), .Req0_LSBFE_i(r0_lsbfe), .Req0_Data_o(r0_dout),
        .Req0_FIFOFull_o(r0_full), .Req0_FIFOEmpty_o(r0_empty), .Req0_Transmission_o(r0_trans),
        .Req1_Request_i(r1_req), .Req1_Grant_o(r1_grant), .Req1_Write_i(r1_wr),
        .Req1_ReadNext_i(r1_rn), .Req1_Data_i(r1_din), .Req1_CPOL_i(r1_cpol),
        .Req1_CPHA_i(r1_cpha), .Req1_LSBFE_i(r1_lsbfe), .Req1_Data_o(r1_dout),
        .Req1_FIFOFull_o(r1_full), .Req1_FIFOEmpty_o(r1_empty), .Req1_Transmission_o(r1_trans),
        .SPI_Write_o(spi_wr), .SPI_ReadNext_o(spi_rn), .SPI_Data_o(spi_dout), .SPI_Data_i(spi_din),
        .SPI_FIFOFull_i(spi_full), .SPI_FIFOEmpty_i(spi_empty), .SPI_Transmission_i(spi_trans),
        .SPI_CPOL_o(spi_cpol), .SPI_CPHA_o(spi_cpha), .SPI_LSBFE_o(spi_lsbfe), .Busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // every forwarded write must match the next byte the bench expects the owner to send
    always @(negedge clk) begin
        if (rst_n && spi_wr) begin
            if (exp_q.size() == 0) check("unexpected_write", 1, 0);
            else check("write_data", spi_dout, exp_q.pop_front());
        end
    end

    initial begin
        rst_n = 0; preset = 0;
        r0_req = 1; r0_wr = 0; r0_rn = 0; r0_din = 0; {r0_cpol, r0_cpha, r0_lsbfe} = 3'b110;
        r1_req = 1; r1_wr = 0; r1_rn = 0; r1_din = 0; {r1_cpol, r1_cpha, r1_lsbfe} = 3'b001;
        spi_din = 0; spi_full = 0; spi_empty = 1; spi_trans = 0;
        tick(); tick();
        check("rst_grants", {r0_grant, r1_grant}, 0);
        check("rst_busy", busy, 0);
        check("rst_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 0);
        check("rst_strobes", {spi_wr, spi_rn}, 0);
        check("rst_status0", {r0_full, r0_empty, r0_trans}, 3'b101);
        check("rst_status1", {r1_full, r1_empty, r1_trans}, 3'b101);
        rst_n = 1;
        tick();
        check("first_grant", {r0_grant, r1_grant}, 2'b10);
        check("first_busy", busy, 1);
        check("first_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 3'b110);
        r0_wr = 1; r0_din = 8'hAA; exp_q.push_back(8'hAA);
        tick();
        r0_wr = 0; r0_rn = 1; #1;
        check("readnext_fwd", spi_rn, 1);
        r0_rn = 0; r1_wr = 1; r1_din = 8'h3C; r0_din = 8'h11; #1;
        check("nonowner_write", spi_wr, 0);
        check("owner_data", spi_dout, 8'h11);
        tick();
        r1_wr = 0; spi_din = 8'h5A; #1;
        check("rdata_bcast", {r0_dout, r1_dout}, 16'h5A5A);
        check("owner_status", {r0_full, r0_empty, r0_trans}, 3'b010);
        check("nonowner_status", {r1_full, r1_empty, r1_trans}, 3'b101);
        r0_req = 0; r0_wr = 1; r0_din = 8'h77; exp_q.push_back(8'h77); #1;
        check("drop_cycle_grant", r0_grant, 1);
        tick();
        r0_wr = 0;
        check("release_busy", busy, 1);
        check("release_grants", {r0_grant, r1_grant}, 0);
        check("release_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 3'b110);
        check("release_status0", r0_trans, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 3'b110);
        tick();
        check("grant1", {r0_grant, r1_grant}, 2'b01);
        check("grant1_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 3'b001);
        r1_wr = 1; r1_din = 8'h42; exp_q.push_back(8'h42);
        tick();
        r1_wr = 0; r1_req = 0;
        tick(); tick();
        check("idle_after_g1", busy, 0);
        preset = 3; r0_req = 1;
        tick();
        check("guard_test_grant", r0_grant, 1);
        spi_trans = 1; spi_empty = 0; r0_wr = 1; r0_din = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        r0_wr = 0; r0_req = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_busy", busy, 1);
            check("hold_grant", r0_grant, 0);
            check("hold_status1", {r1_full, r1_trans}, 2'b11);
            tick();
        end
        spi_trans = 0; spi_empty = 1; r0_req = 1; #1;
        check("drain_grant", r0_grant, 0);
        tick();
        preset = 9;
        for (int i = 0; i < 3; i++) begin
            check("guard_busy", busy, 1);
            check("guard_grant", r0_grant, 0);
            tick();
        end
        check("post_guard_idle", {busy, r0_grant}, 0);
        tick();
        check("post_guard_grant", r0_grant, 1);
        preset = 0; r0_req = 0;
        tick(); tick();
        r0_req = 1; r1_req = 1; exp_owner = 1;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 10 && !(r0_grant || r1_grant); w++) tick();
            if (!(r0_grant || r1_grant)) check("alt_timeout", 0, 1);
            owner = r1_grant ? 1 : 0;
            check("alt_owner", owner, exp_owner);
            exp_owner = 1 - exp_owner;
            if (owner == 1) r1_req = 0; else r0_req = 0;
            tick();
            r0_req = 1; r1_req = 1;
        end
        for (int w = 0; w < 10 && !r1_grant; w++) tick();
        check("pre_reset_grant1", r1_grant, 1);
        spi_trans = 1; spi_empty = 0; r1_din = 8'h99; #1;
        check("pre_reset_data", spi_dout, 8'h99);
        rst_n = 0; #1;
        check("mid_rst_grants", {r0_grant, r1_grant}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", spi_dout, 0);
        check("mid_rst_mode", {spi_cpol, spi_cpha, spi_lsbfe}, 0);
        check("mid_rst_status1", {r1_full, r1_empty, r1_trans}, 3'b101);
        r1_req = 0; r0_req = 1;
        tick();
        rst_n = 1;
        tick();
        check("post_rst_grant", r0_grant, 1);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Shares one SPI master between two sensor-side SPI sequencers, each driving its own sensor chip select, so that two measurement apps run on a single SPI peripheral. Arbitration is round-robin with a held grant: a requester owns the master from grant until it drops its request, and the master must drain before ownership changes. A programmable guard interval between owners gives the SPI bus and chip selects a recovery time. Sits between the SPI master ports of the reconfigurable module and two sequencer instances.

## Interface
- DataWidth, 8, SPI data byte width
- GuardWidth, 16, width of the guard-interval counter and its preset

- Clk_i  in  1  clock, rising edge
- Reset_n_i  in  1  asynchronous, active-low reset
- ParamGuardPreset_i  in  GuardWidth  idle cycles inserted between owners (0 = none)
- ReqN_Request_i  in  1  ownership request, N in {0,1}
- ReqN_Grant_o  out  1  ownership granted
- ReqN_Write_i, ReqN_ReadNext_i  in  1  SPI strobes from requester N
- ReqN_Data_i  in  DataWidth  write byte from requester N
- ReqN_CPOL_i, ReqN_CPHA_i, ReqN_LSBFE_i  in  1  SPI mode wanted by requester N
- ReqN_Data_o  out  DataWidth  read byte (SPI_Data_i broadcast)
- ReqN_FIFOFull_o, ReqN_FIFOEmpty_o, ReqN_Transmission_o  out  1  master status as seen by N
- SPI_Write_o, SPI_ReadNext_o  out  1  strobes to SPI master
- SPI_Data_o  out  DataWidth  write byte to SPI master
- SPI_Data_i  in  DataWidth  read byte from SPI master
- SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i  in  1  SPI master status
- SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o  out  1  registered SPI mode
- Busy_o  out  1  high in any state but Idle

## Operation
- States: Idle, Grant0, Grant1, Release, Guard. Last-owner register Last (reset 1, so requester 0 wins first tie).
- Idle: only Req0 -> Grant0; only Req1 -> Grant1; both -> Grant(not Last); none -> stay. On entry to GrantN: Last<=N, SPI mode outputs load ReqN_CPOL/CPHA/LSBFE.
- GrantN: stay while ReqN_Request_i=1; on 0 -> Release. Other requester's request is ignored until Idle.
- Release: when SPI_Transmission_i=0 and SPI_FIFOEmpty_i=1: preset=0 -> Idle, else Guard with counter<=ParamGuardPreset_i. Else stay.
- Guard: counter decrements each cycle; counter=1 -> Idle. Guard lasts exactly preset cycles.
- ReqN_Grant_o = (state==GrantN), decoded from state register.
- Muxing (combinational on state): in GrantN, SPI_Write_o/ReadNext_o/Data_o = ReqN inputs; in every other state strobes 0, SPI_Data_o 0.
- Owner status: ReqN_FIFOFull/Empty/Transmission_o = SPI inputs passed through. Non-owner (any state other than GrantN): FIFOFull_o=1, FIFOEmpty_o=0, Transmission_o=1.
- ReqN_Data_o = SPI_Data_i always.
- SPI mode outputs held through Release and Guard; change only on grant entry.

## Timing
- Reset: state Idle, Last=1, counter 0, all Grant_o 0, SPI_Write_o/ReadNext_o 0, SPI_Data_o 0, SPI mode outputs 0, Busy_o 0; non-owner status values on both requester sides.
- Request seen in Idle at edge n -> Grant_o high from cycle n+1; first forwardable strobe in cycle n+1.
- Strobe in the same cycle the owner drops its request is still forwarded (state still GrantN).
- Release exit: condition sampled at edge k -> Guard (or Idle if preset 0) in cycle k+1.
- Minimum owner-to-owner gap: Release(>=1) + preset + Idle(1) cycles.
- Reset mid-transaction: immediate return to reset values; SPI master is not drained.
- Preset change during Guard has no effect until next load.

## Test plan
- Reset with both requests high -> after release Grant0 at cycle 1, SPI mode = Req0 mode, Busy_o=1.
- Req0 only, writes 0xA5 then drops request, SPI_Transmission_i high 5 cycles, preset 3 -> SPI_Write_o/Data_o=0xA5 forwarded, Release 5 cycles, Guard 3 cycles, Idle, Grant0_o never high while Req1 status shows FIFOFull=1/Transmission=1.
- Both requests held continuously, preset 0 -> grants alternate 0,1,0,1 with no back-to-back same owner.
- Non-owner Req1 pulses Write with 0x3C during Grant0 -> SPI_Write_o stays 0, SPI_Data_o shows Req0 byte.
- Req0 mode (1,1,0), Req1 mode (0,0,1) -> SPI mode outputs switch only on Grant1 entry, unchanged during Release/Guard.
- Assert Reset_n_i during Grant1 with Transmission high -> all outputs at reset values same cycle; next Req0 granted one cycle after reset release.
